// File: rtl/input_pad_stream.sv
// Streams a SIZE x SIZE raster frame out as a zero/constant padded OUT_SIZE x OUT_SIZE
// frame through a single valid/ready register stage, flagging framing errors on in_sof.
module input_pad_stream #(
  parameter int DATA_W      = 32,
  parameter int CHANNELS    = 1,
  parameter int SIZE        = 5,
  parameter int FILTER_SIZE = 3,
  parameter int PAD         = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [DATA_W-1:0]            pad_value,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W*CHANNELS-1:0]   in_data,
  input  logic                         in_sof,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W*CHANNELS-1:0]   out_data,
  output logic                         out_sof,
  output logic                         out_eol,
  output logic                         out_eof,
  output logic                         busy,
  output logic                         err
);

  localparam int OUT_SIZE = ((SIZE + 2*PAD + FILTER_SIZE - 1) / FILTER_SIZE) * FILTER_SIZE;
  localparam int CW       = $clog2(OUT_SIZE + 1);
  localparam logic [CW-1:0] LAST   = CW'(OUT_SIZE - 1);
  localparam logic [CW-1:0] PAD_LO = CW'(PAD);
  localparam logic [CW-1:0] SIZE_C = CW'(SIZE);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_d;
  logic [1:0]        rst_sync;
  logic              rst_n;
  logic [CW-1:0]     r, c;
  logic [DATA_W-1:0] pad_q;
  logic              row_in, col_in, pad_pos, load_ok, advance, last_pos, first_pos;

  // Assert asynchronously, release two clocks after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Unsigned wrap makes positions before PAD compare as out of range.
  assign row_in    = (r - PAD_LO) < SIZE_C;
  assign col_in    = (c - PAD_LO) < SIZE_C;
  assign pad_pos   = !(row_in && col_in);
  assign load_ok   = !out_valid || out_ready;
  assign advance   = (state == RUN) && load_ok && (pad_pos || in_valid);
  assign last_pos  = (r == LAST) && (c == LAST);
  assign first_pos = (r == PAD_LO) && (c == PAD_LO);

  assign in_ready  = (state == RUN) && !pad_pos && load_ok;
  assign busy      = (state != IDLE);

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (advance && last_pos) state_d = DRAIN;
      DRAIN:   if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r         <= '0;
      c         <= '0;
      pad_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        pad_q <= pad_value;
        r     <= '0;
        c     <= '0;
      end
      if (advance) begin
        out_valid <= 1'b1;
        out_data  <= pad_pos ? {CHANNELS{pad_q}} : in_data;
        out_sof   <= (r == '0) && (c == '0);
        out_eol   <= (c == LAST);
        out_eof   <= last_pos;
        if (c == LAST) begin
          c <= '0;
          r <= (r == LAST) ? '0 : r + 1'b1;
        end else begin
          c <= c + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (in_valid && in_ready && (in_sof != first_pos)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_input_pad_stream.sv
// Bench for input_pad_stream: frame table replayed with random handshakes against
// a position-based padding model, plus a PAD=0 pass-through instance.
module tb_input_pad_stream;

  localparam int SZ = 5, PD = 1, OS = 9, NIN = 25, NOUT = 81;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_start = 0, a_in_valid = 0, a_in_sof = 0, a_out_ready = 0;
  logic [31:0] a_pad_value = '0;
  logic [63:0] a_in_data = '0;
  logic        a_in_ready, a_out_valid, a_out_sof, a_out_eol, a_out_eof, a_busy, a_err;
  logic [63:0] a_out_data;

  logic        b_start = 0, b_in_valid = 0, b_in_sof = 0, b_out_ready = 0;
  logic [15:0] b_pad_value = 16'hBEEF;
  logic [15:0] b_in_data = '0;
  logic        b_in_ready, b_out_valid, b_out_sof, b_out_eol, b_out_eof, b_busy, b_err;
  logic [15:0] b_out_data;

  input_pad_stream #(.DATA_W(32), .CHANNELS(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(a_start), .pad_value(a_pad_value),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_sof(a_in_sof),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_sof(a_out_sof), .out_eol(a_out_eol), .out_eof(a_out_eof), .busy(a_busy), .err(a_err)
  );

  input_pad_stream #(.DATA_W(16), .CHANNELS(1), .SIZE(6), .FILTER_SIZE(3), .PAD(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(b_start), .pad_value(b_pad_value),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_sof(b_in_sof),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_sof(b_out_sof), .out_eol(b_out_eol), .out_eof(b_out_eof), .busy(b_busy), .err(b_err)
  );

  int checks = 0, errors = 0;
  bit err_exp = 0;
  logic [63:0] pix[NIN];
  int row1[OS] = '{0, 1, 2, 3, 4, 5, 0, 0, 0};

  typedef struct {
    logic [31:0] pad;
    int unsigned rdy;
    int unsigned vld;
    int          sof_idx;
    bit          seq;
    bit          start_noise;
    int          abort_at;
  } frame_t;
  frame_t tbl[8];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit is_pad(int k);
    int r = k / OS;
    int c = k % OS;
    return !(r >= PD && r < PD + SZ && c >= PD && c < PD + SZ);
  endfunction

  function automatic logic [66:0] model(int k, logic [31:0] pad);
    int r = k / OS;
    int c = k % OS;
    logic [63:0] d;
    if (is_pad(k)) d = {pad, pad};
    else           d = pix[(r - PD) * SZ + (c - PD)];
    return {d, k == 0, c == OS - 1, k == NOUT - 1};
  endfunction

  task automatic run_frame(input frame_t f);
    int in_idx = 0, out_idx = 0, cyc = 0, ld;
    bit stall = 0, bad;
    logic [66:0] held = '0, got;
    for (int i = 0; i < NIN; i++)
      pix[i] = f.seq ? {32'(i + 101), 32'(i + 1)} : {$urandom, $urandom};
    a_pad_value = f.pad;
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    a_pad_value = ~f.pad;
    check("busy_after_start", a_busy, 1);
    while (out_idx < NOUT && cyc < 4000) begin
      a_out_ready = ($urandom % 100) < f.rdy;
      a_in_valid  = (in_idx < NIN) && (($urandom % 100) < f.vld);
      a_in_data   = (in_idx < NIN) ? pix[in_idx] : '0;
      a_in_sof    = (in_idx == f.sof_idx);
      if (f.start_noise) a_start = $urandom % 2;
      #1;
      got = {a_out_data, a_out_sof, a_out_eol, a_out_eof};
      if (stall) check("stall_hold", {a_out_valid, got}, {1'b1, held});
      ld = out_idx + int'(a_out_valid);
      if (ld >= NOUT || is_pad(ld)) check("in_ready_pad", a_in_ready, 0);
      if (a_out_valid && a_out_ready) begin
        check($sformatf("beat%0d", out_idx), got, model(out_idx, f.pad));
        if (f.seq && f.pad == 0 && out_idx / OS == 1)
          check("row1", a_out_data[31:0], row1[out_idx % OS]);
        out_idx++;
      end
      stall = a_out_valid && !a_out_ready;
      held  = got;
      bad   = a_in_valid && a_in_ready && (a_in_sof != (in_idx == 0));
      if (a_in_valid && a_in_ready) in_idx++;
      if (f.abort_at > 0 && out_idx == f.abort_at) begin
        reset_n = 0;
        #1;
        check("abort_out_valid", a_out_valid, 0);
        check("abort_busy", a_busy, 0);
        check("abort_data", a_out_data, 0);
        a_start = 0;
        a_in_valid = 0;
        @(negedge clk);
        reset_n = 1;
        repeat (3) @(negedge clk);
        err_exp = 0;
        return;
      end
      @(negedge clk);
      cyc++;
      if (bad) begin
        err_exp = 1;
        check("err_set", a_err, 1);
      end
    end
    a_start = 0;
    a_in_valid = 0;
    a_out_ready = 0;
    check("out_beats", out_idx, NOUT);
    check("in_beats", in_idx, NIN);
    check("idle_after_frame", {a_busy, a_out_valid}, 0);
    check("err_frame", a_err, err_exp);
  endtask

  task automatic run_b();
    logic [15:0] bpix[36];
    logic [15:0] q[$];
    logic [15:0] e;
    int n_in = 0, n_out = 0, cyc = 0;
    for (int i = 0; i < 36; i++) bpix[i] = 16'($urandom);
    b_start = 1;
    @(negedge clk);
    b_start = 0;
    while (n_out < 36 && cyc < 1000) begin
      b_out_ready = ($urandom % 4) != 0;
      b_in_valid  = n_in < 36;
      b_in_data   = (n_in < 36) ? bpix[n_in] : '0;
      b_in_sof    = (n_in == 0);
      b_start     = (cyc == 10);
      #1;
      if (b_out_valid && b_out_ready) begin
        e = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
        check("b_beat", {b_out_data, b_out_sof, b_out_eol, b_out_eof},
              {e, n_out == 0, (n_out % 6) == 5, n_out == 35});
        n_out++;
      end
      if (b_in_valid && b_in_ready) begin
        q.push_back(b_in_data);
        n_in++;
      end
      @(negedge clk);
      cyc++;
    end
    b_start = 0;
    b_in_valid = 0;
    check("b_out_beats", n_out, 36);
    check("b_in_beats", n_in, 36);
    check("b_idle_err", {b_busy, b_err}, 0);
  endtask

  initial begin
    tbl[0] = '{32'h0000_0000, 100, 100, 0, 1'b1, 1'b0, 0};
    tbl[1] = '{32'hFFFF_FFFF, 100, 100, 0, 1'b0, 1'b0, 0};
    tbl[2] = '{32'h0000_0000,  50,  60, 0, 1'b1, 1'b0, 0};
    tbl[3] = '{32'hA5A5_0F0F,  30,  80, 0, 1'b0, 1'b1, 0};
    tbl[4] = '{32'h0000_0000, 100, 100, 2, 1'b1, 1'b0, 0};
    tbl[5] = '{32'h1234_5678,  70,  70, 0, 1'b0, 1'b0, 0};
    tbl[6] = '{32'h0000_0000, 100, 100, 0, 1'b1, 1'b0, 40};
    tbl[7] = '{32'h0000_0000, 100, 100, 0, 1'b1, 1'b0, 0};

    reset_n = 0;
    a_in_valid = 1;
    a_start = 1;
    repeat (3) @(negedge clk);
    check("reset_a", {a_out_valid, a_out_sof, a_out_eol, a_out_eof, a_in_ready, a_busy, a_err, a_out_data}, 0);
    check("reset_b", {b_out_valid, b_in_ready, b_busy, b_err, b_out_data}, 0);
    a_in_valid = 0;
    a_start = 0;
    reset_n = 1;
    repeat (3) @(negedge clk);
    check("idle_no_start", a_busy, 0);

    for (int i = 0; i < 8; i++) run_frame(tbl[i]);
    run_b();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
